interrupt_ack_sequencer: RTL and testbench
==========================================

// Module: interrupt_ack_sequencer
// PURPOSE
//  - Sequences the In-Service Register (ISR) datapath of the 8259 core.
//  - Runs the 8086-mode two-pulse INTA handshake and drives the ISR latch strobe and the vector byte.
//  - Decodes OCW2 commands (EOI, rotate, set-priority) into end_of_interrupt pulses and the priority_rotate value.
//  - Sits between the bus/control decoder, the request priority resolver and the ISR block.
// PARAMETERS
//  - INT_LEVELS      8  number of IR levels; only 8 is supported
//  - SPURIOUS_LEVEL  7  IR index used as the vector when no request is pending at the first INTA
// PORTS
//  - clock                  in   1  system clock; all state changes on the rising edge
//  - reset                  in   1  synchronous, active-high reset
//  - inta_n                 in   1  INTA strobe, already synchronised to clock, active low
//  - interrupt              in   8  one-hot highest-priority pending request from the resolver (0 = none)
//  - highest_level_in_service in 8  one-hot highest ISR level from the ISR block (0 = none)
//  - ocw2_write             in   1  one-cycle strobe: ocw2_data is valid
//  - ocw2_data              in   8  OCW2 byte; [7]=R, [6]=SL, [5]=EOI, [2:0]=L
//  - auto_eoi_config        in   1  ICW4 AEOI bit
//  - vector_base            in   5  ICW2 T7..T3
//  - latch_in_service       out  1  one-cycle ISR set strobe
//  - in_service_interrupt   out  8  one-hot level to set in the ISR; valid while latch_in_service=1, else 0
//  - end_of_interrupt       out  8  one-cycle ISR clear mask
//  - priority_rotate        out  3  index of the lowest-priority level, fed to the ISR and the resolver
//  - freeze                 out  1  high from the first INTA fall until the second INTA rise; resolver holds its output
//  - vector_oe              out  1  data-bus drive enable during the second INTA
//  - vector_data            out  8  {vector_base, level index}
// BEHAVIOUR
//  - Reset values: all outputs 0 except priority_rotate=3'd7 (IR0 highest). Internal state: FSM=IDLE, rotate_in_aeoi=0.
//  - inta_prev is a register, reset to 0, so an INTA already low when reset releases is ignored.
//      fall = inta_prev & ~inta_n
//      rise = ~inta_prev & inta_n
//  - All outputs are registered: they become visible 1 cycle after the causing sample.
//  - FSM states and transitions:
//      IDLE  --fall-->  ACK1
//        on this edge: capture acked = interrupt, or 1<<SPURIOUS_LEVEL if interrupt==0
//        latch_in_service=1 for 1 cycle only when interrupt!=0 (spurious requests never set the ISR)
//        freeze=1
//      ACK1  --rise-->  GAP
//      GAP   --fall-->  ACK2
//        vector_oe=1; vector_data={vector_base, idx(acked)}
//        both held stable until leaving ACK2
//      ACK2  --rise-->  IDLE
//        vector_oe=0; freeze=0
//        if auto_eoi_config and the request was not spurious: end_of_interrupt=acked for 1 cycle
//        if rotate_in_aeoi is also set: priority_rotate=idx(acked)
//  - A rise in IDLE and any edge not listed above are ignored.
//  - OCW2 decode of {R,SL,EOI}, applied on ocw2_write; result is registered:
//      001  non-specific EOI: eom = highest_level_in_service
//      011  specific EOI: eom = 1<<L
//      101  rotate on non-specific EOI: eom = highest; priority_rotate = idx(highest); no rotate if highest==0
//      111  rotate on specific EOI: eom = 1<<L; priority_rotate = L
//      110  set priority: priority_rotate = L
//      100  set rotate_in_aeoi
//      000  clear rotate_in_aeoi
//      010  no operation
//  - end_of_interrupt = OCW2 eom | AEOI mask. Both in one cycle: OR the masks; OCW2 rotate wins.
//  - end_of_interrupt always returns to 0 the cycle after a pulse. Back-to-back ocw2_write gives back-to-back pulses.
//  - ocw2_write during an INTA sequence is honoured and does not disturb the FSM.
//  - Reset in any state returns to IDLE in 1 cycle with the reset values above; a partial ack produces no EOI.
//  - idx(): one-hot to index; a zero input gives 0, and the caller gates its use.
// STRUCTURE
//  - Package pic8259_pkg:
//      FSM state encoding
//      OCW2 command constants
//      function onehot_to_index(logic [7:0]) -> logic [2:0]
//  - Sub-module ocw2_decoder: combinational, ocw2_data + highest -> {eom, rotate_valid, rotate_value, aeoi_set, aeoi_clr}
//  - Top: inta edge detect, FSM, and output registers.
// TESTING
//  - Normal ack: interrupt=8'h08, vector_base=5'h04, two INTA pulses
//      -> latch_in_service 1 cycle with in_service_interrupt=8'h08
//      -> vector_data=8'h23 with vector_oe=1 during the second pulse
//      -> no EOI
//  - AEOI + rotate: auto_eoi_config=1, OCW2=8'h80, then ack of interrupt=8'h20
//      -> end_of_interrupt=8'h20 1 cycle after the second rise; priority_rotate=5
//  - Spurious: interrupt=0 at the first fall
//      -> no latch_in_service; vector_data={vector_base,3'd7}; no EOI even with AEOI
//  - OCW2 sequence:
//      8'h20 with highest=8'h04 -> end_of_interrupt=8'h04
//      8'h66                    -> end_of_interrupt=8'h40
//      8'hC3                    -> priority_rotate=3
//      8'hA0 with highest=8'h10 -> end_of_interrupt=8'h10; priority_rotate=4
//  - Collision: OCW2 specific EOI L=1 in the same cycle as the AEOI completion of 8'h08
//      -> end_of_interrupt=8'h0A in 1 cycle
//  - Reset during GAP
//      -> next cycle freeze=0, vector_oe=0, priority_rotate=7
//      -> a following INTA rise produces no EOI and no vector

Source files
------------

// File: rtl/pic8259_pkg.sv
// Shared definitions for the 8259 interrupt acknowledge / ISR sequencing logic:
// acknowledge FSM encoding, OCW2 command codes and a one-hot to index helper.
package pic8259_pkg;

   // Acknowledge sequence states (8086-mode two-pulse INTA)
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for the first INTA fall
      ST_ACK1 = 2'd1,   // first INTA pulse low, request captured
      ST_GAP  = 2'd2,   // between the two INTA pulses
      ST_ACK2 = 2'd3    // second INTA pulse low, vector on the bus
   } ack_state_t;

   // OCW2 {R, SL, EOI} command codes
   localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
   localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0] OCW2_NOP          = 3'b010;
   localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
   localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
   localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
   localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
   localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

   // Lowest priority level after reset: IR7, which makes IR0 the highest
   localparam logic [2:0] ROTATE_RESET = 3'd7;

   // One-hot level to index; a zero (or malformed) input yields 0 and the
   // caller decides whether the result is meaningful.
   function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
      logic [2:0] idx;
      idx = 3'd0;
      case (onehot)
         8'h01:   idx = 3'd0;
         8'h02:   idx = 3'd1;
         8'h04:   idx = 3'd2;
         8'h08:   idx = 3'd3;
         8'h10:   idx = 3'd4;
         8'h20:   idx = 3'd5;
         8'h40:   idx = 3'd6;
         8'h80:   idx = 3'd7;
         default: idx = 3'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/ocw2_decoder.sv
// Combinational OCW2 command decoder: turns the {R, SL, EOI, L} fields into an
// ISR clear mask, an optional new lowest-priority level and the AEOI-rotate
// mode set/clear requests. The caller gates everything with the write strobe.
module ocw2_decoder
   import pic8259_pkg::*;
(
   input  logic [7:0] ocw2_data,
   input  logic [7:0] highest,
   output logic [7:0] eom,
   output logic       rotate_valid,
   output logic [2:0] rotate_value,
   output logic       aeoi_set,
   output logic       aeoi_clr
);

   logic [2:0] command_s;
   logic [2:0] level_s;
   logic [7:0] level_mask_s;
   logic       unused_bits_s;

   assign command_s     = ocw2_data[7:5];
   assign level_s       = ocw2_data[2:0];
   assign level_mask_s  = 8'h01 << level_s;
   // Bits 4:3 select OCW2 vs OCW3/ICW1 upstream and carry no meaning here
   assign unused_bits_s = &{1'b0, ocw2_data[4:3]};

   // Decode the command field into mask / rotate / mode results
   always_comb begin
      eom          = 8'h00;
      rotate_valid = 1'b0;
      rotate_value = 3'd0;
      aeoi_set     = 1'b0;
      aeoi_clr     = 1'b0;
      case (command_s)
         OCW2_NS_EOI: begin
            eom = highest;
         end
         OCW2_SP_EOI: begin
            eom = level_mask_s;
         end
         OCW2_ROT_NS_EOI: begin
            eom = highest;
            // Nothing in service means there is no level to rotate to
            rotate_valid = (highest != 8'h00);
            rotate_value = onehot_to_index(highest);
         end
         OCW2_ROT_SP_EOI: begin
            eom          = level_mask_s;
            rotate_valid = 1'b1;
            rotate_value = level_s;
         end
         OCW2_SET_PRI: begin
            rotate_valid = 1'b1;
            rotate_value = level_s;
         end
         OCW2_ROT_AEOI_SET: begin
            aeoi_set = 1'b1;
         end
         OCW2_ROT_AEOI_CLR: begin
            aeoi_clr = 1'b1;
         end
         OCW2_NOP: begin
            eom = 8'h00;
         end
         default: begin
            eom = 8'h00;
         end
      endcase
   end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259 ISR datapath sequencer: runs the 8086-mode two-pulse INTA handshake,
// strobes the ISR latch, drives the vector byte, and merges OCW2 and
// automatic EOI into end_of_interrupt / priority_rotate. All outputs are
// registered and appear one cycle after the sample that causes them.
module interrupt_ack_sequencer
   import pic8259_pkg::*;
#(
   parameter int INT_LEVELS     = 8,
   parameter int SPURIOUS_LEVEL = 7
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  inta_n,
   input  logic [INT_LEVELS-1:0] interrupt,
   input  logic [INT_LEVELS-1:0] highest_level_in_service,
   input  logic                  ocw2_write,
   input  logic [7:0]            ocw2_data,
   input  logic                  auto_eoi_config,
   input  logic [4:0]            vector_base,
   output logic                  latch_in_service,
   output logic [INT_LEVELS-1:0] in_service_interrupt,
   output logic [INT_LEVELS-1:0] end_of_interrupt,
   output logic [2:0]            priority_rotate,
   output logic                  freeze,
   output logic                  vector_oe,
   output logic [7:0]            vector_data
);

   localparam logic [INT_LEVELS-1:0] LEVEL_NONE    = {INT_LEVELS{1'b0}};
   localparam logic [INT_LEVELS-1:0] SPURIOUS_MASK =
      {{(INT_LEVELS-1){1'b0}}, 1'b1} << SPURIOUS_LEVEL;

   // INTA edge detection
   logic inta_prev_r;
   logic fall_s;
   logic rise_s;

   // FSM and captured request
   ack_state_t            state_r;
   ack_state_t            state_nx_s;
   logic [INT_LEVELS-1:0] acked_r;
   logic [INT_LEVELS-1:0] acked_nx_s;
   logic                  spurious_r;
   logic                  spurious_nx_s;
   logic                  rotate_in_aeoi_r;
   logic                  rotate_in_aeoi_nx_s;

   // Output registers and their next values
   logic                  latch_r;
   logic                  latch_nx_s;
   logic [INT_LEVELS-1:0] isi_r;
   logic [INT_LEVELS-1:0] isi_nx_s;
   logic [INT_LEVELS-1:0] eoi_r;
   logic [INT_LEVELS-1:0] eoi_nx_s;
   logic [2:0]            rotate_r;
   logic [2:0]            rotate_nx_s;
   logic                  freeze_r;
   logic                  freeze_nx_s;
   logic                  oe_r;
   logic                  oe_nx_s;
   logic [7:0]            vdata_r;
   logic [7:0]            vdata_nx_s;

   // Automatic EOI produced by the end of the second INTA pulse
   logic [INT_LEVELS-1:0] aeoi_mask_s;
   logic                  aeoi_rotate_s;

   // OCW2 decoder results
   logic [7:0] dec_eom_s;
   logic       dec_rotate_valid_s;
   logic [2:0] dec_rotate_value_s;
   logic       dec_aeoi_set_s;
   logic       dec_aeoi_clr_s;
   logic [7:0] ocw2_eom_s;

   assign fall_s = inta_prev_r & ~inta_n;
   assign rise_s = ~inta_prev_r & inta_n;

   ocw2_decoder u_ocw2_decoder (
      .ocw2_data    (ocw2_data),
      .highest      (highest_level_in_service),
      .eom          (dec_eom_s),
      .rotate_valid (dec_rotate_valid_s),
      .rotate_value (dec_rotate_value_s),
      .aeoi_set     (dec_aeoi_set_s),
      .aeoi_clr     (dec_aeoi_clr_s)
   );

   assign ocw2_eom_s = ocw2_write ? dec_eom_s : 8'h00;

   // Previous INTA level; cleared by reset so a strobe already low is ignored
   always_ff @(posedge clock) begin
      if (reset) begin
         inta_prev_r <= 1'b0;
      end else begin
         inta_prev_r <= inta_n;
      end
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next state and handshake-driven output next values
   always_comb begin
      state_nx_s    = state_r;
      acked_nx_s    = acked_r;
      spurious_nx_s = spurious_r;
      latch_nx_s    = 1'b0;
      isi_nx_s      = LEVEL_NONE;
      freeze_nx_s   = freeze_r;
      oe_nx_s       = oe_r;
      vdata_nx_s    = vdata_r;
      aeoi_mask_s   = LEVEL_NONE;
      aeoi_rotate_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fall_s) begin
               state_nx_s  = ST_ACK1;
               freeze_nx_s = 1'b1;
               if (interrupt != LEVEL_NONE) begin
                  acked_nx_s    = interrupt;
                  spurious_nx_s = 1'b0;
                  latch_nx_s    = 1'b1;
                  isi_nx_s      = interrupt;
               end else begin
                  // Nothing pending: answer with the spurious level, ISR untouched
                  acked_nx_s    = SPURIOUS_MASK;
                  spurious_nx_s = 1'b1;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ACK1: begin
            if (rise_s) begin
               state_nx_s = ST_GAP;
            end else begin
               state_nx_s = ST_ACK1;
            end
         end
         ST_GAP: begin
            if (fall_s) begin
               state_nx_s = ST_ACK2;
               oe_nx_s    = 1'b1;
               vdata_nx_s = {vector_base, onehot_to_index(acked_r)};
            end else begin
               state_nx_s = ST_GAP;
            end
         end
         ST_ACK2: begin
            if (rise_s) begin
               state_nx_s  = ST_IDLE;
               oe_nx_s     = 1'b0;
               freeze_nx_s = 1'b0;
               vdata_nx_s  = 8'h00;
               if (auto_eoi_config && !spurious_r) begin
                  aeoi_mask_s   = acked_r;
                  aeoi_rotate_s = rotate_in_aeoi_r;
               end else begin
                  aeoi_mask_s   = LEVEL_NONE;
                  aeoi_rotate_s = 1'b0;
               end
            end else begin
               state_nx_s = ST_ACK2;
            end
         end
         default: begin
            state_nx_s  = ST_IDLE;
            oe_nx_s     = 1'b0;
            freeze_nx_s = 1'b0;
            vdata_nx_s  = 8'h00;
         end
      endcase
   end

   // Merge OCW2 and automatic EOI; an explicit OCW2 rotate takes precedence
   always_comb begin
      eoi_nx_s = ocw2_eom_s | aeoi_mask_s;
      if (ocw2_write && dec_rotate_valid_s) begin
         rotate_nx_s = dec_rotate_value_s;
      end else if (aeoi_rotate_s) begin
         rotate_nx_s = onehot_to_index(acked_r);
      end else begin
         rotate_nx_s = rotate_r;
      end
      if (ocw2_write && dec_aeoi_set_s) begin
         rotate_in_aeoi_nx_s = 1'b1;
      end else if (ocw2_write && dec_aeoi_clr_s) begin
         rotate_in_aeoi_nx_s = 1'b0;
      end else begin
         rotate_in_aeoi_nx_s = rotate_in_aeoi_r;
      end
   end

   // Captured request and rotate-in-AEOI mode
   always_ff @(posedge clock) begin
      if (reset) begin
         acked_r          <= LEVEL_NONE;
         spurious_r       <= 1'b0;
         rotate_in_aeoi_r <= 1'b0;
      end else begin
         acked_r          <= acked_nx_s;
         spurious_r       <= spurious_nx_s;
         rotate_in_aeoi_r <= rotate_in_aeoi_nx_s;
      end
   end

   // Output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         latch_r  <= 1'b0;
         isi_r    <= LEVEL_NONE;
         eoi_r    <= LEVEL_NONE;
         rotate_r <= ROTATE_RESET;
         freeze_r <= 1'b0;
         oe_r     <= 1'b0;
         vdata_r  <= 8'h00;
      end else begin
         latch_r  <= latch_nx_s;
         isi_r    <= isi_nx_s;
         eoi_r    <= eoi_nx_s;
         rotate_r <= rotate_nx_s;
         freeze_r <= freeze_nx_s;
         oe_r     <= oe_nx_s;
         vdata_r  <= vdata_nx_s;
      end
   end

   assign latch_in_service     = latch_r;
   assign in_service_interrupt = isi_r;
   assign end_of_interrupt     = eoi_r;
   assign priority_rotate      = rotate_r;
   assign freeze               = freeze_r;
   assign vector_oe            = oe_r;
   assign vector_data          = vdata_r;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed, table-driven bench for interrupt_ack_sequencer. Each table row is
// applied for one clock; the registered outputs are compared 1 ns after the
// rising edge. Hand-written sequences cover reset in the middle of an ack.
module tb_interrupt_ack_sequencer;

   logic       clock;
   logic       reset;
   logic       inta_n;
   logic [7:0] interrupt;
   logic [7:0] highest_level_in_service;
   logic       ocw2_write;
   logic [7:0] ocw2_data;
   logic       auto_eoi_config;
   logic [4:0] vector_base;
   logic       latch_in_service;
   logic [7:0] in_service_interrupt;
   logic [7:0] end_of_interrupt;
   logic [2:0] priority_rotate;
   logic       freeze;
   logic       vector_oe;
   logic [7:0] vector_data;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      name;
      logic       rst;
      logic       inta;
      logic [7:0] intr;
      logic [7:0] hi;
      logic       wr;
      logic [7:0] od;
      logic       aeoi;
      logic       e_latch;
      logic [7:0] e_isi;
      logic [7:0] e_eoi;
      logic [2:0] e_rot;
      logic       e_frz;
      logic       e_oe;
      logic [7:0] e_vd;
   } vec_t;

   vec_t vecs[$];

   interrupt_ack_sequencer dut (
      .clock                    (clock),
      .reset                    (reset),
      .inta_n                   (inta_n),
      .interrupt                (interrupt),
      .highest_level_in_service (highest_level_in_service),
      .ocw2_write               (ocw2_write),
      .ocw2_data                (ocw2_data),
      .auto_eoi_config          (auto_eoi_config),
      .vector_base              (vector_base),
      .latch_in_service         (latch_in_service),
      .in_service_interrupt     (in_service_interrupt),
      .end_of_interrupt         (end_of_interrupt),
      .priority_rotate          (priority_rotate),
      .freeze                   (freeze),
      .vector_oe                (vector_oe),
      .vector_data              (vector_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(string n, logic rst, logic inta, logic [7:0] intr,
                               logic [7:0] hi, logic wr, logic [7:0] od, logic aeoi,
                               logic lat, logic [7:0] isi, logic [7:0] eoi,
                               logic [2:0] rot, logic frz, logic oe, logic [7:0] vd);
      vec_t v;
      v.name = n; v.rst = rst; v.inta = inta; v.intr = intr; v.hi = hi;
      v.wr = wr; v.od = od; v.aeoi = aeoi; v.e_latch = lat; v.e_isi = isi;
      v.e_eoi = eoi; v.e_rot = rot; v.e_frz = frz; v.e_oe = oe; v.e_vd = vd;
      return v;
   endfunction

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(logic rst, logic inta, logic [7:0] intr, logic [7:0] hi,
                        logic wr, logic [7:0] od, logic aeoi);
      reset = rst; inta_n = inta; interrupt = intr; highest_level_in_service = hi;
      ocw2_write = wr; ocw2_data = od; auto_eoi_config = aeoi;
   endtask

   initial begin
      vector_base = 5'h04;
      drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

      //            name         rst  inta  intr   hi     wr   od     aeoi  lat  isi    eoi    rot   frz  oe   vd
      vecs.push_back(mk("reset",   1'b1,1'b1,8'h00,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,3'd7,1'b0,1'b0,8'h00));
      vecs.push_back(mk("idle",    1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,3'd7,1'b0,1'b0,8'h00));
      // normal ack of IR3 with base 0x04
      vecs.push_back(mk("ack1",    1'b0,1'b0,8'h08,8'h00,1'b0,8'h00,1'b0, 1'b1,8'h08,8'h00,3'd7,1'b1,1'b0,8'h00));
      vecs.push_back(mk("ack1h",   1'b0,1'b0,8'h08,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,3'd7,1'b1,1'b0,8'h00));
      vecs.push_back(mk("gap",     1'b0,1'b1,8'h08,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,3'd7,1'b1,1'b0,8'h00));
      vecs.push_back(mk("ack2",    1'b0,1'b0,8'h08,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,3'd7,1'b1,1'b1,8'h23));
      vecs.push_back(mk("ack2h",   1'b0,1'b0,8'h00,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,3'd7,1'b1,1'b1,8'h23));
      vecs.push_back(mk("done",    1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,3'd7,1'b0,1'b0,8'h00));
      // OCW2 sequence
      vecs.push_back(mk("ns_eoi",  1'b0,1'b1,8'h00,8'h04,1'b1,8'h20,1'b0, 1'b0,8'h00,8'h04,3'd7,1'b0,1'b0,8'h00));
      vecs.push_back(mk("eoi_clr", 1'b0,1'b1,8'h00,8'h04,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,3'd7,1'b0,1'b0,8'h00));
      vecs.push_back(mk("sp_eoi",  1'b0,1'b1,8'h00,8'h00,1'b1,8'h66,1'b0, 1'b0,8'h00,8'h40,3'd7,1'b0,1'b0,8'h00));
      vecs.push_back(mk("set_pri", 1'b0,1'b1,8'h00,8'h00,1'b1,8'hC3,1'b0, 1'b0,8'h00,8'h00,3'd3,1'b0,1'b0,8'h00));
      vecs.push_back(mk("rot_ns",  1'b0,1'b1,8'h00,8'h10,1'b1,8'hA0,1'b0, 1'b0,8'h00,8'h10,3'd4,1'b0,1'b0,8'h00));
      vecs.push_back(mk("rot_hold",1'b0,1'b1,8'h00,8'h10,1'b0,8'h00,1'b0, 1'b0,8'h00,8'h00,3'd4,1'b0,1'b0,8'h00));
      // AEOI with rotate on IR5
      vecs.push_back(mk("aeoi_set",1'b0,1'b1,8'h00,8'h00,1'b1,8'h80,1'b1, 1'b0,8'h00,8'h00,3'd4,1'b0,1'b0,8'h00));
      vecs.push_back(mk("a_ack1",  1'b0,1'b0,8'h20,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h20,8'h00,3'd4,1'b1,1'b0,8'h00));
      vecs.push_back(mk("a_gap",   1'b0,1'b1,8'h20,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd4,1'b1,1'b0,8'h00));
      vecs.push_back(mk("a_ack2",  1'b0,1'b0,8'h20,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd4,1'b1,1'b1,8'h25));
      vecs.push_back(mk("a_done",  1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h20,3'd5,1'b0,1'b0,8'h00));
      vecs.push_back(mk("a_after", 1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b0,1'b0,8'h00));
      // spurious ack with AEOI enabled
      vecs.push_back(mk("s_ack1",  1'b0,1'b0,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b1,1'b0,8'h00));
      vecs.push_back(mk("s_gap",   1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b1,1'b0,8'h00));
      vecs.push_back(mk("s_ack2",  1'b0,1'b0,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b1,1'b1,8'h27));
      vecs.push_back(mk("s_done",  1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b0,1'b0,8'h00));
      // collision: specific EOI L=1 with AEOI of IR3, rotate-in-AEOI off
      vecs.push_back(mk("aeoi_clr",1'b0,1'b1,8'h00,8'h00,1'b1,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b0,1'b0,8'h00));
      vecs.push_back(mk("c_ack1",  1'b0,1'b0,8'h08,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h08,8'h00,3'd5,1'b1,1'b0,8'h00));
      vecs.push_back(mk("c_gap",   1'b0,1'b1,8'h08,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b1,1'b0,8'h00));
      vecs.push_back(mk("c_ack2",  1'b0,1'b0,8'h08,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b1,1'b1,8'h23));
      vecs.push_back(mk("c_done",  1'b0,1'b1,8'h00,8'h00,1'b1,8'h61,1'b1, 1'b0,8'h00,8'h0A,3'd5,1'b0,1'b0,8'h00));
      vecs.push_back(mk("c_after", 1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b0,1'b0,8'h00));
      // OCW2 set-priority beats rotate-in-AEOI in the same cycle
      vecs.push_back(mk("r_set",   1'b0,1'b1,8'h00,8'h00,1'b1,8'h80,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b0,1'b0,8'h00));
      vecs.push_back(mk("r_ack1",  1'b0,1'b0,8'h08,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h08,8'h00,3'd5,1'b1,1'b0,8'h00));
      vecs.push_back(mk("r_gap",   1'b0,1'b1,8'h08,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b1,1'b0,8'h00));
      vecs.push_back(mk("r_ack2",  1'b0,1'b0,8'h08,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd5,1'b1,1'b1,8'h23));
      vecs.push_back(mk("r_done",  1'b0,1'b1,8'h00,8'h00,1'b1,8'hC1,1'b1, 1'b0,8'h00,8'h08,3'd1,1'b0,1'b0,8'h00));
      vecs.push_back(mk("r_after", 1'b0,1'b1,8'h00,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,8'h00,3'd1,1'b0,1'b0,8'h00));
      // rotate on non-specific EOI with nothing in service: no change
      vecs.push_back(mk("rot_none",1'b0,1'b1,8'h00,8'h00,1'b1,8'hA0,1'b1, 1'b0,8'h00,8'h00,3'd1,1'b0,1'b0,8'h00));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].inta, vecs[i].intr, vecs[i].hi,
               vecs[i].wr, vecs[i].od, vecs[i].aeoi);
         tick();
         chk({vecs[i].name, ".latch"}, {7'd0, latch_in_service}, {7'd0, vecs[i].e_latch});
         chk({vecs[i].name, ".isi"},   in_service_interrupt, vecs[i].e_isi);
         chk({vecs[i].name, ".eoi"},   end_of_interrupt, vecs[i].e_eoi);
         chk({vecs[i].name, ".rot"},   {5'd0, priority_rotate}, {5'd0, vecs[i].e_rot});
         chk({vecs[i].name, ".freeze"}, {7'd0, freeze}, {7'd0, vecs[i].e_frz});
         chk({vecs[i].name, ".oe"},    {7'd0, vector_oe}, {7'd0, vecs[i].e_oe});
         if (vecs[i].e_oe) begin
            chk({vecs[i].name, ".vdata"}, vector_data, vecs[i].e_vd);
         end
      end

      // Reset while in GAP (rotate-in-AEOI currently set, rotate=1)
      drive(1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      chk("rg_ack1.latch", {7'd0, latch_in_service}, 8'h01);
      drive(1'b0, 1'b1, 8'h08, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      chk("rg_gap.freeze", {7'd0, freeze}, 8'h01);
      drive(1'b1, 1'b1, 8'h08, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      chk("rg_rst.freeze", {7'd0, freeze}, 8'h00);
      chk("rg_rst.oe",     {7'd0, vector_oe}, 8'h00);
      chk("rg_rst.rot",    {5'd0, priority_rotate}, 8'h07);
      // INTA pulse that would have been the second one: ignored
      drive(1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      chk("rg_low.oe",     {7'd0, vector_oe}, 8'h00);
      chk("rg_low.latch",  {7'd0, latch_in_service}, 8'h00);
      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      chk("rg_rise.eoi",   end_of_interrupt, 8'h00);
      chk("rg_rise.oe",    {7'd0, vector_oe}, 8'h00);
      chk("rg_rise.freeze", {7'd0, freeze}, 8'h00);

      // Fresh AEOI ack after reset: rotate-in-AEOI was cleared, rotate stays 7
      drive(1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      chk("post_ack1.isi", in_service_interrupt, 8'h08);
      drive(1'b0, 1'b1, 8'h08, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      drive(1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      chk("post_ack2.vdata", vector_data, 8'h23);
      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      chk("post_done.eoi", end_of_interrupt, 8'h08);
      chk("post_done.rot", {5'd0, priority_rotate}, 8'h07);
      tick();
      chk("post_after.eoi", end_of_interrupt, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
